// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register bank.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input with rise/fall pulses
// derived from the last two synchronised samples.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Synchroniser chain plus one delayed sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_r <= '0;
            prev_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign q    = chain_r[STAGES-1];
    assign rise = q & ~prev_r;
    assign fall = ~q & prev_r;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-frame decoder holding the five PWM control registers.
// Optional readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

    logic sclk_q, sclk_rise, sclk_fall;
    logic copi_q;
    logic ncs_q, ncs_rise, ncs_fall;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst(rst), .d(copi), .q(copi_q), .rise(), .fall()
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst(rst), .d(ncs), .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall)
    );

    state_t                      state_r, state_nxt;
    logic [FRAME_BITS-1:0]       shift_r, shift_nxt;
    logic [CNT_W-1:0]            cnt_r, cnt_nxt;
    logic                        ovf_r, ovf_nxt;
    logic [7:0]                  regs_r [0:4];
    logic                        wr_strobe_r;
    logic                        commit_ok_s;
    logic [6:0]                  wr_addr_s;

    // Next-state and frame-capture logic
    always_comb begin
        state_nxt = state_r;
        shift_nxt = shift_r;
        cnt_nxt   = cnt_r;
        ovf_nxt   = ovf_r;
        case (state_r)
            IDLE: begin
                if (ncs_fall) begin
                    state_nxt = SHIFT;
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_nxt = COMMIT;
                end else if (sclk_rise) begin
                    // A bit beyond the sixteenth marks the frame as too long
                    if (cnt_r == FULL_CNT) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        shift_nxt = {shift_r[FRAME_BITS-2:0], copi_q};
                        cnt_nxt   = cnt_r + 5'd1;
                    end
                end else begin
                    state_nxt = SHIFT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign wr_addr_s   = shift_r[14:8];
    assign commit_ok_s = (state_r == COMMIT) && (cnt_r == FULL_CNT) && !ovf_r &&
                         shift_r[15] && (wr_addr_s <= MAX_ADDR);

    // FSM and frame registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            shift_r <= '0;
            cnt_r   <= '0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt;
            shift_r <= shift_nxt;
            cnt_r   <= cnt_nxt;
            ovf_r   <= ovf_nxt;
        end
    end

    // Control registers and write strobe, updated together on commit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                regs_r[i] <= 8'h00;
            end
            wr_strobe_r <= 1'b0;
        end else begin
            wr_strobe_r <= commit_ok_s;
            if (commit_ok_s) begin
                case (wr_addr_s)
                    ADDR_EN_OUT_LO: regs_r[0] <= shift_r[7:0];
                    ADDR_EN_OUT_HI: regs_r[1] <= shift_r[7:0];
                    ADDR_EN_PWM_LO: regs_r[2] <= shift_r[7:0];
                    ADDR_EN_PWM_HI: regs_r[3] <= shift_r[7:0];
                    ADDR_DUTY:      regs_r[4] <= shift_r[7:0];
                    default:        ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = regs_r[0];
    assign en_reg_out_15_8 = regs_r[1];
    assign en_reg_pwm_7_0  = regs_r[2];
    assign en_reg_pwm_15_8 = regs_r[3];
    assign pwm_duty_cycle  = regs_r[4];
    assign wr_strobe       = wr_strobe_r;

`ifdef SPI_READBACK_EN
    logic [7:0] rd_word_s;
    logic [7:0] rd_data_r;
    logic       rd_act_r;
    logic       cipo_r;
    logic       rd_ok_s;

    // Register selected by the address just shifted in (bits 14:8 sit in shift_r[6:0])
    always_comb begin
        rd_word_s = 8'h00;
        case (shift_r[6:0])
            ADDR_EN_OUT_LO: rd_word_s = regs_r[0];
            ADDR_EN_OUT_HI: rd_word_s = regs_r[1];
            ADDR_EN_PWM_LO: rd_word_s = regs_r[2];
            ADDR_EN_PWM_HI: rd_word_s = regs_r[3];
            ADDR_DUTY:      rd_word_s = regs_r[4];
            default:        rd_word_s = 8'h00;
        endcase
    end

    assign rd_ok_s = !shift_r[7] && (shift_r[6:0] <= MAX_ADDR);

    // Readback shifter: load after the eighth bit, advance on each sclk fall
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= 8'h00;
            rd_act_r  <= 1'b0;
            cipo_r    <= 1'b0;
        end else if (state_r != SHIFT) begin
            rd_act_r  <= 1'b0;
            cipo_r    <= 1'b0;
        end else if (sclk_fall) begin
            if (cnt_r == 5'd8) begin
                rd_act_r  <= rd_ok_s;
                cipo_r    <= rd_ok_s & rd_word_s[7];
                rd_data_r <= {rd_word_s[6:0], 1'b0};
            end else if ((cnt_r > 5'd8) && (cnt_r < FULL_CNT)) begin
                cipo_r    <= rd_act_r & rd_data_r[7];
                rd_data_r <= {rd_data_r[6:0], 1'b0};
            end else begin
                cipo_r    <= 1'b0;
            end
        end else begin
            cipo_r <= cipo_r;
        end
    end

    assign cipo = cipo_r;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Table-driven bench with an expected-state scoreboard for spi_reg_bank.
module tb_spi_reg_bank;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst, sclk, copi, ncs;
    logic       cipo, wr_strobe;
    logic [7:0] r0, r1, r2, r3, r4;

    always #5 clk = ~clk;

    spi_reg_bank #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
        .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .wr_strobe(wr_strobe)
    );

    typedef struct {
        string       name;
        logic [31:0] word;
        int          nbits;
        logic        wr;
        int          addr;
        logic [7:0]  data;
    } vec_t;

    typedef struct {
        int              strobes;
        logic [4:0][7:0] regs;
    } exp_t;

    vec_t            vecs [9];
    exp_t            sb_q [$];
    logic [4:0][7:0] model;
    int              n_vec = 0;
    int              n_err = 0;
    int              strobe_cycles = 0;
    int              strobe_pulses = 0;
    logic            strobe_prev = 1'b0;

    // Strobe monitor: total high cycles and distinct pulses
    always @(negedge clk) begin
        if (wr_strobe) strobe_cycles <= strobe_cycles + 1;
        if (wr_strobe && !strobe_prev) strobe_pulses <= strobe_pulses + 1;
        strobe_prev <= wr_strobe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bit(input logic b, output logic cap);
        copi = b;
        clk_wait(4);
        cap  = cipo;
        sclk = 1'b1;
        clk_wait(4);
        sclk = 1'b0;
    endtask

    task automatic finish_frame(output int lat);
        clk_wait(4);
        ncs = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (wr_strobe && lat == 0) lat = k;
        end
        clk_wait(4);
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits,
                              output logic [31:0] rx, output int lat);
        logic c;
        rx  = 32'h0;
        ncs = 1'b0;
        clk_wait(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            put_bit(word[i], c);
            rx[i] = c;
        end
        finish_frame(lat);
    endtask

    task automatic check_regs(input string tag, input exp_t e);
        check({tag, ".r0"}, {24'h0, r0}, {24'h0, e.regs[0]});
        check({tag, ".r1"}, {24'h0, r1}, {24'h0, e.regs[1]});
        check({tag, ".r2"}, {24'h0, r2}, {24'h0, e.regs[2]});
        check({tag, ".r3"}, {24'h0, r3}, {24'h0, e.regs[3]});
        check({tag, ".r4"}, {24'h0, r4}, {24'h0, e.regs[4]});
    endtask

    task automatic run_frame(input string tag, input logic [31:0] word, input int nbits,
                             input logic wr, input int addr, input logic [7:0] data,
                             output logic [31:0] rx);
        exp_t e;
        int   lat, c0, p0;
        if (wr) model[addr] = data;
        e.strobes = wr ? 1 : 0;
        e.regs    = model;
        sb_q.push_back(e);
        c0 = strobe_cycles;
        p0 = strobe_pulses;
        send_frame(word, nbits, rx, lat);
        e = sb_q.pop_front();
        check_regs(tag, e);
        check({tag, ".pulses"}, strobe_pulses - p0, e.strobes);
        check({tag, ".cycles"}, strobe_cycles - c0, e.strobes);
        if (wr) begin
            check({tag, ".lat_ok"}, {31'h0, (lat >= SYNC + 1) && (lat <= SYNC + 2)}, 32'h1);
        end
    endtask

    initial begin
        logic [31:0] rx;
        logic        c;
        int          lat, c0, p0;
        exp_t        e;

        vecs[0] = '{"wr_duty",   32'h8480,          16, 1'b1, 4, 8'h80};
        vecs[1] = '{"wr_out_lo", 32'h80FF,          16, 1'b1, 0, 8'hFF};
        vecs[2] = '{"wr_pwm_lo", 32'h8255,          16, 1'b1, 2, 8'h55};
        vecs[3] = '{"short15",   32'h8177 >> 1,     15, 1'b0, 0, 8'h00};
        vecs[4] = '{"long17",    {15'h0, 16'h8177, 1'b1}, 17, 1'b0, 0, 8'h00};
        vecs[5] = '{"bad_addr",  32'h8A33,          16, 1'b0, 0, 8'h00};
        vecs[6] = '{"read_drop", 32'h0433,          16, 1'b0, 0, 8'h00};
        vecs[7] = '{"ncs_glitch", 32'h0,             0, 1'b0, 0, 8'h00};
        vecs[8] = '{"wr_pwm_hi", 32'h83A5,          16, 1'b1, 3, 8'hA5};

        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        model = '0;
        clk_wait(4);
        rst = 1'b0;
        clk_wait(4);
        e.strobes = 0;
        e.regs    = '0;
        check_regs("reset", e);
        check("reset.strobe", {31'h0, wr_strobe}, 32'h0);
        check("reset.cipo", {31'h0, cipo}, 32'h0);

        foreach (vecs[i]) begin
            run_frame(vecs[i].name, vecs[i].word, vecs[i].nbits, vecs[i].wr,
                      vecs[i].addr, vecs[i].data, rx);
        end

        // Reset after eight bits, released with ncs still low; frame must be lost
        c0 = strobe_cycles;
        p0 = strobe_pulses;
        ncs = 1'b0;
        clk_wait(4);
        for (int i = 15; i >= 8; i--) put_bit(vecs[0].word[0] ^ vecs[0].word[0] ^ logic'((32'h8112 >> i) & 32'h1), c);
        rst = 1'b1;
        clk_wait(3);
        rst = 1'b0;
        model = '0;
        for (int i = 7; i >= 0; i--) put_bit(logic'((32'h8112 >> i) & 32'h1), c);
        finish_frame(lat);
        e.strobes = 0;
        e.regs    = model;
        check_regs("midrst", e);
        check("midrst.pulses", strobe_pulses - p0, 32'h0);

        run_frame("clean_8112", 32'h8112, 16, 1'b1, 1, 8'h12, rx);
        run_frame("wr_a5",      32'h83A5, 16, 1'b1, 3, 8'hA5, rx);
        run_frame("read_0300",  32'h0300, 16, 1'b0, 0, 8'h00, rx);
`ifdef SPI_READBACK_EN
        check("readback.cipo", {16'h0, rx[15:0]}, 32'h00A5);
`else
        check("readback.cipo", {16'h0, rx[15:0]}, 32'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
SPI-mode-0 peripheral that decodes 16-bit serial write frames from the host and holds the five 8-bit control registers consumed by the PWM peripheral: output enables, PWM enables and duty cycle. It sits directly upstream of the PWM stage in the top-level wrapper. Its inputs are sclk, copi and ncs on ui_in[0], ui_in[1] and ui_in[2]. All SPI pins are asynchronous to clk and are synchronised internally.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (legal values >= 2)
- MAX_ADDR, 7'h04, highest implemented register address; writes above it are dropped

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sclk  in  1  SPI clock, asynchronous
- copi  in  1  SPI data from host, asynchronous
- ncs  in  1  SPI chip select, active low, asynchronous
- cipo  out  1  SPI data to host (see Optional Feature)
- en_reg_out_7_0  out  8  register at address 0x00
- en_reg_out_15_8  out  8  register at address 0x01
- en_reg_pwm_7_0  out  8  register at address 0x02
- en_reg_pwm_15_8  out  8  register at address 0x03
- pwm_duty_cycle  out  8  register at address 0x04
- wr_strobe  out  1  one-cycle pulse on each accepted register write

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all five registers = 8'h00, wr_strobe = 0, cipo = 0, FSM = IDLE, shift register and bit counter cleared.
- Synchronisation: sclk, copi and ncs each pass through SYNC_STAGES flops before use. Edges are detected from the last two synchronised samples.
- Timing limit: each sclk high and low phase must be >= 3 clk periods. Faster sclk is unsupported.
- Frame format: 16 bits, MSB first, sampled on the sclk rising edge.
  - bit15 = R/W (1 = write)
  - bits14:8 = address
  - bits7:0 = data
- FSM states:
  - IDLE: on synchronised ncs falling edge -> SHIFT; clear bit counter and overflow flag.
  - SHIFT: on each sclk rising edge, shift in copi and increment the counter (saturates at 16). A rising edge while count == 16 sets the overflow flag. On ncs rising edge -> COMMIT.
  - COMMIT (1 cycle): write data to the addressed register only if count == 16, overflow == 0, R/W == 1 and addr <= MAX_ADDR. Pulse wr_strobe in that same cycle. Then -> IDLE.
- Commit latency: the register value and wr_strobe appear SYNC_STAGES+1 to SYNC_STAGES+2 clk cycles after the raw ncs rising edge.
- Discarded frames (registers unchanged, no strobe):
  - short frame (<16 bits)
  - long frame (>16 bits)
  - read frame
  - address > MAX_ADDR
- ncs glitch: ncs high with zero bits shifted -> COMMIT with count 0 -> no write.
- Reset mid-frame: FSM -> IDLE and the partial frame is lost. If ncs is still low when rst deasserts, stay in IDLE until a fresh ncs falling edge. No write for that frame.
- Simultaneous rst and COMMIT: rst wins; registers = 0.
- Register outputs are driven directly from flops and hold their value between writes.

Optional Feature:
- SPI_READBACK_EN defined:
  - A frame with R/W = 0 and addr <= MAX_ADDR returns the addressed register on cipo, MSB first, during frame bits 7:0.
  - cipo is updated on the synchronised sclk falling edge after bit 8 is sampled.
  - cipo = 0 at all other times and for addresses > MAX_ADDR.
  - Read frames never modify registers.
- SPI_READBACK_EN undefined: cipo tied to 0; read frames are silently discarded.

Decomposition:
- Package spi_reg_pkg:
  - FRAME_BITS = 16
  - address constants ADDR_EN_OUT_LO/HI, ADDR_EN_PWM_LO/HI, ADDR_DUTY
  - FSM state enum {IDLE, SHIFT, COMMIT}
- Sub-module spi_sync: SYNC_STAGES-deep synchroniser with rise/fall pulse outputs, instantiated once each for sclk, copi and ncs (edge outputs unused for copi).

Test Plan:
- Write to address 0x04: frame 0x8480 (R/W=1, addr 0x04, data 0x80) at sclk = clk/8 -> pwm_duty_cycle = 0x80 within SYNC_STAGES+2 cycles of ncs rise; wr_strobe high for exactly 1 cycle; other registers unchanged.
- Sequential writes: frame 0x80FF then frame 0x8255 -> en_reg_out_7_0 = 0xFF, en_reg_pwm_7_0 = 0x55, two separate strobes.
- Short frame: frame of 15 bits, then ncs high -> no change, no strobe.
- Long frame: frame of 17 bits, then ncs high -> no change, no strobe.
- Dropped frames: out-of-range address frame 0x8A33 (addr 0x0A) and read frame 0x0433 -> no register change, no strobe.
- Reset mid-frame: assert rst after 8 bits of frame 0x8112, deassert with ncs still low, finish the frame -> en_reg_out_15_8 stays 0x00. A following clean frame 0x8112 -> en_reg_out_15_8 = 0x12.
- Readback (SPI_READBACK_EN only): after writing 0xA5 to address 0x03, read frame 0x0300 -> cipo shifts 1,0,1,0,0,1,0,1 during bits 7:0.
